// File: rtl/conv_window_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_window_sched                                                          |
// | Loads an image into the row-memory bank and streams every 3x3 window out.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv_window_sched #(
  parameter int DATA_W  = 8,
  parameter int IMG_DIM = 8,
  parameter int KSIZE   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            pix_valid,
  input  logic [DATA_W-1:0]               pix_data,
  output logic                            pix_ready,
  output logic [IMG_DIM-1:0]              ram_we,
  output logic [$clog2(IMG_DIM)-1:0]      ram_addr,
  output logic [DATA_W-1:0]               ram_din,
  input  logic [IMG_DIM*DATA_W-1:0]       ram_dout,
  output logic                            win_valid,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   win_data,
  output logic [$clog2(IMG_DIM)-1:0]      win_row,
  output logic [$clog2(IMG_DIM)-1:0]      win_col,
  input  logic                            win_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = $clog2(IMG_DIM);
  localparam int KW = $clog2(KSIZE + 1);
  localparam logic [AW-1:0] LAST_POS = AW'(IMG_DIM - KSIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(IMG_DIM - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RD, OUT, FIN} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     ld_r, ld_c, wr, wc;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] win_q   [KSIZE][KSIZE];
  logic [DATA_W-1:0] rows    [IMG_DIM];
  logic [AW-1:0]     row_sel [KSIZE];
  logic              last_pix;

  for (genvar r = 0; r < IMG_DIM; r++) begin : g_rows
    assign rows[r] = ram_dout[r*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < KSIZE; i++) begin : g_sel
    assign row_sel[i] = wr + AW'(i);
  end

  for (genvar i = 0; i < KSIZE; i++) begin : g_win_i
    for (genvar j = 0; j < KSIZE; j++) begin : g_win_j
      assign win_data[(KSIZE*i+j)*DATA_W +: DATA_W] = win_q[i][j];
    end
  end

  assign last_pix = (ld_r == LAST_IDX) && (ld_c == LAST_IDX);
  assign win_row  = wr;
  assign win_col  = wc;

  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_din   = '0;
    win_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          ram_we   = IMG_DIM'(1) << ld_r;
          ram_addr = ld_c;
          ram_din  = pix_data;
          if (last_pix) state_nx = RD;
        end
      end
      RD: begin
        // Address column k now; its data lands one cycle later.
        if (k < KW'(KSIZE)) ram_addr = wc + AW'(k);
        if (k == KW'(KSIZE)) state_nx = OUT;
      end
      OUT: begin
        win_valid = 1'b1;
        if (win_ready) state_nx = (wc == LAST_POS && wr == LAST_POS) ? FIN : RD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ld_r  <= '0;
      ld_c  <= '0;
      wr    <= '0;
      wc    <= '0;
      k     <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++)
          win_q[i][j] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            ld_r <= '0;
            ld_c <= '0;
          end
        end
        LOAD: begin
          if (pix_valid) begin
            ld_c <= (ld_c == LAST_IDX) ? '0 : ld_c + 1'b1;
            if (ld_c == LAST_IDX) ld_r <= ld_r + 1'b1;
            if (last_pix) begin
              wr <= '0;
              wc <= '0;
              k  <= '0;
            end
          end
        end
        RD: begin
          k <= k + 1'b1;
          for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
              if (k == KW'(j + 1)) win_q[i][j] <= rows[row_sel[i]];
        end
        OUT: begin
          if (win_ready) begin
            k <= '0;
            if (wc != LAST_POS) begin
              wc <= wc + 1'b1;
            end else if (wr != LAST_POS) begin
              wc <= '0;
              wr <= wr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_window_sched                                                       |
// | Directed jobs against an image-array reference model of the window scan.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conv_window_sched;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int K  = 3;
  localparam int NW = N - K + 1;

  logic            clk = 1'b0;
  logic            rst_n, start, pix_valid, win_ready;
  logic [DW-1:0]   pix_data;
  logic            pix_ready, win_valid, busy, done;
  logic [N-1:0]    ram_we;
  logic [2:0]      ram_addr, win_row, win_col;
  logic [DW-1:0]   ram_din;
  logic [N*DW-1:0] ram_dout;
  logic [K*K*DW-1:0] win_data;

  logic [DW-1:0]   mem [N][N];
  logic [DW-1:0]   img [N][N];
  int unsigned     cyc = 0;
  int              total = 0;
  int              bad = 0;
  int unsigned     hs;

  conv_window_sched #(.DATA_W(DW), .IMG_DIM(N), .KSIZE(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .win_ready(win_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Row-memory bank: registered read, one cycle latency.
  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (ram_we[r]) mem[r][ram_addr] <= ram_din;
      ram_dout[r*DW +: DW] <= mem[r][ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*K*DW-1:0] exp_win(input int r0, input int c0);
    logic [K*K*DW-1:0] v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[(K*i+j)*DW +: DW] = img[r0+i][c0+j];
    return v;
  endfunction

  task automatic zero_outs();
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_img(input int npix, input bit gaps, output int unsigned hcyc);
    logic [N-1:0] we_exp;
    hcyc = 0;
    for (int n = 0; n < npix; n++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        #1;
        chk("stall_we", ram_we, 0);
        @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_data  = img[n/N][n%N];
      we_exp    = '0;
      we_exp[n/N] = 1'b1;
      #1;
      chk("ld_ready", pix_ready, 1);
      chk("ld_we", ram_we, we_exp);
      chk("ld_addr", ram_addr, n % N);
      chk("ld_din", ram_din, img[n/N][n%N]);
      hcyc = cyc;
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic scan(input int unsigned h, input bit timed, input bit stall8,
                      input bit rnd_ready, input bit pokes);
    int waited;
    logic [2:0] a;
    for (int w = 0; w < NW*NW; w++) begin
      int er = w / NW;
      int ec = w % NW;
      waited = 0;
      while (win_valid !== 1'b1 && waited < 40) begin
        if (waited < K) chk("rd_addr", ram_addr, ec + waited);
        chk("rd_we", ram_we, 0);
        if (pokes && w == 3 && waited == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited++;
      end
      chk("win_valid", win_valid, 1);
      chk("rd_cycles", waited, K + 1);
      if (timed) chk("win_time", cyc, h + 5*(w+1));
      chk("win_row", win_row, er);
      chk("win_col", win_col, ec);
      chk("win_data", win_data, exp_win(er, ec));
      chk("scan_done", done, 0);
      chk("scan_busy", busy, 1);
      if (stall8 && w == 8) begin
        win_ready = 1'b0;
        a = ram_addr;
        repeat (7) begin
          if (pokes) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          #1;
          chk("hold_valid", win_valid, 1);
          chk("hold_data", win_data, exp_win(er, ec));
          chk("hold_row", win_row, er);
          chk("hold_col", win_col, ec);
          chk("hold_addr", ram_addr, a);
          chk("hold_we", ram_we, 0);
        end
      end else if (rnd_ready) begin
        repeat ($urandom_range(0, 3)) begin
          win_ready = 1'b0;
          @(negedge clk);
          chk("bp_data", win_data, exp_win(er, ec));
        end
      end
      win_ready = 1'b1;
      #1;
      if (timed && w == NW*NW-1) chk("scan_len", cyc - h, 180);
      @(negedge clk);
      chk("valid_drop", win_valid, 0);
    end
    chk("done_pulse", done, 1);
    chk("fin_busy", busy, 1);
    if (timed) chk("done_time", cyc, h + 181);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    zero_outs();
    rst_n = 1'b1;
    @(negedge clk);

    // Partial load of a random image, then reset mid-LOAD.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = 8'($urandom);
    pulse_start();
    load_img(10, 1'b0, hs);
    pix_valid = 1'b1;
    pix_data  = 8'h5a;
    rst_n     = 1'b0;
    #1;
    zero_outs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_we", ram_we, 0);
    pix_valid = 1'b0;
    @(negedge clk);

    // Directed pattern image, ready held high, cycle-exact timing.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = (r == N-1) ? 8'(-64 + c) : 8'(8*r + c);
    win_ready = 1'b1;
    pulse_start();
    load_img(64, 1'b0, hs);
    chk("ready_drop", pix_ready, 0);
    scan(hs, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random image with load gaps, backpressure and ignored start pulses.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = 8'($urandom);
    pulse_start();
    load_img(64, 1'b1, hs);
    chk("ready_drop2", pix_ready, 0);
    scan(hs, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("stay_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
